axi4_frame_writer: RTL

//  Parametrised stream-to-memory-mapped write master (S2MM). Accepts a pixel stream already
//  in the clk_100Mhz domain, buffers it in an internal sync FIFO and writes fixed-length
//  AXI4 INCR bursts into a ring of NUM_BUFS frame buffers in PS DDR. Advances the write

---
 rtl/axi4_frame_writer_if.sv | 34 +++
 rtl/axi4_frame_writer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/axi4_frame_writer_if.sv
// AXI4 write-only bus (AW, W and B channels) between the frame writer and the DDR port.
interface axi4_frame_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awvalid, awlen, awsize, awburst, awcache, awprot,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, awlen, awsize, awburst, awcache, awprot,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi4_frame_writer.sv
// Stream-to-DDR frame writer: FWFT FIFO feeding fixed-length AXI4 INCR bursts into a buffer ring.
// Optional SOF_RESYNC_EN: a start-of-frame seen mid-frame abandons the partial frame.
module axi4_frame_writer #(
    parameter int                DATA_W      = 64,
    parameter int                ADDR_W      = 32,
    parameter int                BURST_LEN   = 64,
    parameter int                FIFO_DEPTH  = 256,
    parameter int                NUM_BUFS    = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] BUF_STRIDE  = 32'h0020_0000,
    parameter int                FRAME_BYTES = 153600
) (
    input  logic                          clk_100Mhz,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          s_tuser,
    axi4_frame_writer_if.master           m_axi,
    input  logic [1:0]                    rd_buf_idx,
    output logic [1:0]                    wr_buf_idx,
    output logic [1:0]                    done_buf_idx,
    output logic                          frame_done,
    output logic                          bresp_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SOF_RESYNC_EN
    localparam int EW = DATA_W + 1;
`else
    localparam int EW = DATA_W;
`endif
    localparam logic [AW:0]       FULL_LVL    = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       BURST_LVL   = (AW+1)'(BURST_LEN);
    localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [ADDR_W-1:0] FRAME_END   = ADDR_W'(FRAME_BYTES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t state;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]       wptr, rptr;
    logic [EW-1:0]     head;
    logic              fifo_wr, fifo_rd;
    logic [ADDR_W-1:0] awaddr_q, offset, offset_nxt, buf_base;
    logic              awvalid_q, wvalid_q, wlast_q;
    logic [7:0]        beat;
    logic [1:0]        step1, next_buf;
    logic              sof_resync;

    // FIFO: data is presented at the head before it is read (first-word fall-through).
    assign fifo_level = wptr - rptr;
    assign s_tready   = (fifo_level != FULL_LVL);
    assign fifo_wr    = s_tvalid && s_tready;
    assign fifo_rd    = wvalid_q && m_axi.wready;
    assign head       = mem[rptr[AW-1:0]];

`ifdef SOF_RESYNC_EN
    always_ff @(posedge clk_100Mhz)
        if (fifo_wr) mem[wptr[AW-1:0]] <= {s_tuser, s_tdata};
    assign sof_resync = (fifo_level != '0) && head[DATA_W] && (offset != '0);
`else
    logic sof_unused;
    assign sof_unused = s_tuser;
    always_ff @(posedge clk_100Mhz)
        if (fifo_wr) mem[wptr[AW-1:0]] <= s_tdata;
    assign sof_resync = 1'b0;
`endif

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (fifo_wr) wptr <= wptr + 1'b1;
            if (fifo_rd) rptr <= rptr + 1'b1;
        end
    end

    function automatic logic [1:0] ring_next(input logic [1:0] i);
        return (i == 2'(NUM_BUFS - 1)) ? 2'd0 : i + 2'd1;
    endfunction

    // Skip the buffer under scan-out; with only two buffers there is nowhere else to go.
    assign step1      = ring_next(wr_buf_idx);
    assign next_buf   = (NUM_BUFS > 2 && step1 == rd_buf_idx) ? ring_next(step1) : step1;
    assign offset_nxt = offset + BURST_BYTES;
    assign buf_base   = BASE_ADDR + ADDR_W'(wr_buf_idx) * BUF_STRIDE;

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            awaddr_q     <= BASE_ADDR;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            beat         <= '0;
            offset       <= '0;
            wr_buf_idx   <= 2'd0;
            done_buf_idx <= 2'(NUM_BUFS - 1);
            frame_done   <= 1'b0;
            bresp_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sof_resync) begin
                        offset <= '0;
                    end else if (enable && fifo_level >= BURST_LVL) begin
                        awaddr_q  <= buf_base + offset;
                        awvalid_q <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (LAST_BEAT == 8'd0);
                        beat      <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (m_axi.wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            state    <= RESP;
                        end else begin
                            beat    <= beat + 8'd1;
                            wlast_q <= (beat + 8'd1 == LAST_BEAT);
                        end
                    end
                end
                RESP: begin
                    if (m_axi.bvalid) begin
                        if (m_axi.bresp != 2'b00) bresp_err <= 1'b1;
                        state <= IDLE;
                        if (offset_nxt == FRAME_END) begin
                            offset       <= '0;
                            done_buf_idx <= wr_buf_idx;
                            frame_done   <= 1'b1;
                            wr_buf_idx   <= next_buf;
                        end else begin
                            offset <= offset_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awlen   = LAST_BEAT;
    assign m_axi.awsize  = 3'($clog2(DATA_W / 8));
    assign m_axi.awburst = 2'b01;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wdata   = head[DATA_W-1:0];
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = wlast_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = 1'b1;
    assign dbg_state     = state;
endmodule
